// File: rtl/hazard_ctrl.sv
// Central hazard controller: shadow E/M/W producer state, D-stage stall,
// forwarding selects and the mult/div HI/LO busy interlock.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A_rsD,
    input  logic [4:0] A_rtD,
    input  logic [1:0] TuseRsD,
    input  logic [1:0] TuseRtD,
    input  logic [4:0] AwriteD,
    input  logic       RegWriteD,
    input  logic [1:0] TnewD,
    input  logic [1:0] md_kindD,
    input  logic       md_useD,
    output logic       stall,
    output logic       flushE,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM,
    output logic       md_busy
);

    logic             we_e_q, we_e_d;
    logic [4:0]       aw_e_q, aw_e_d;
    logic [1:0]       tn_e_q, tn_e_d;
    logic [4:0]       rs_e_q, rs_e_d;
    logic [4:0]       rt_e_q, rt_e_d;
    logic [1:0]       kind_e_q, kind_e_d;
    logic             we_m_q, we_m_d;
    logic [4:0]       aw_m_q, aw_m_d;
    logic [1:0]       tn_m_q, tn_m_d;
    logic [4:0]       rt_m_q, rt_m_d;
    logic             we_w_q, we_w_d;
    logic [4:0]       aw_w_q, aw_w_d;
    logic [1:0]       tn_w_q, tn_w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stall_rs, stall_rt, stall_md;

    function automatic logic hit(input logic we, input logic [4:0] aw,
                                 input logic [4:0] r);
        return we && (aw == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    assign md_busy  = (cnt_q != '0) || (kind_e_q != 2'd0);
    assign stall_rs = (hit(we_e_q, aw_e_q, A_rsD) && (tn_e_q > TuseRsD))
                   || (hit(we_m_q, aw_m_q, A_rsD) && (tn_m_q > TuseRsD));
    assign stall_rt = (hit(we_e_q, aw_e_q, A_rtD) && (tn_e_q > TuseRtD))
                   || (hit(we_m_q, aw_m_q, A_rtD) && (tn_m_q > TuseRtD));
    assign stall_md = md_useD && md_busy;
    assign stall    = stall_rs || stall_rt || stall_md;
    assign flushE   = stall;

    // Only producers whose result already exists (Tnew=0) may forward.
    always_comb begin
        fwd_rsD = 2'd0;
        if (hit(we_e_q, aw_e_q, A_rsD) && tn_e_q == 2'd0)
            fwd_rsD = 2'd1;
        else if (hit(we_m_q, aw_m_q, A_rsD) && tn_m_q == 2'd0)
            fwd_rsD = 2'd2;
        else if (hit(we_w_q, aw_w_q, A_rsD) && tn_w_q == 2'd0)
            fwd_rsD = 2'd3;

        fwd_rtD = 2'd0;
        if (hit(we_e_q, aw_e_q, A_rtD) && tn_e_q == 2'd0)
            fwd_rtD = 2'd1;
        else if (hit(we_m_q, aw_m_q, A_rtD) && tn_m_q == 2'd0)
            fwd_rtD = 2'd2;
        else if (hit(we_w_q, aw_w_q, A_rtD) && tn_w_q == 2'd0)
            fwd_rtD = 2'd3;

        fwd_rsE = 2'd0;
        if (hit(we_m_q, aw_m_q, rs_e_q) && tn_m_q == 2'd0)
            fwd_rsE = 2'd1;
        else if (hit(we_w_q, aw_w_q, rs_e_q) && tn_w_q == 2'd0)
            fwd_rsE = 2'd2;

        fwd_rtE = 2'd0;
        if (hit(we_m_q, aw_m_q, rt_e_q) && tn_m_q == 2'd0)
            fwd_rtE = 2'd1;
        else if (hit(we_w_q, aw_w_q, rt_e_q) && tn_w_q == 2'd0)
            fwd_rtE = 2'd2;

        fwd_rtM = hit(we_w_q, aw_w_q, rt_m_q) && tn_w_q == 2'd0;
    end

    always_comb begin
        we_e_d   = stall ? 1'b0 : RegWriteD;
        aw_e_d   = stall ? 5'd0 : AwriteD;
        tn_e_d   = stall ? 2'd0 : TnewD;
        rs_e_d   = stall ? 5'd0 : A_rsD;
        rt_e_d   = stall ? 5'd0 : A_rtD;
        kind_e_d = stall ? 2'd0 : md_kindD;
        we_m_d   = we_e_q;
        aw_m_d   = aw_e_q;
        tn_m_d   = dec_sat(tn_e_q);
        rt_m_d   = rt_e_q;
        we_w_d   = we_m_q;
        aw_w_d   = aw_m_q;
        tn_w_d   = dec_sat(tn_m_q);
        // A new mult/div in E always reloads, even over a pending count.
        if (kind_e_q == 2'd1)
            cnt_d = CNT_W'(MULT_CYCLES);
        else if (kind_e_q != 2'd0)
            cnt_d = CNT_W'(DIV_CYCLES);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_e_q   <= 1'b0;
            aw_e_q   <= 5'd0;
            tn_e_q   <= 2'd0;
            rs_e_q   <= 5'd0;
            rt_e_q   <= 5'd0;
            kind_e_q <= 2'd0;
            we_m_q   <= 1'b0;
            aw_m_q   <= 5'd0;
            tn_m_q   <= 2'd0;
            rt_m_q   <= 5'd0;
            we_w_q   <= 1'b0;
            aw_w_q   <= 5'd0;
            tn_w_q   <= 2'd0;
            cnt_q    <= '0;
        end else begin
            we_e_q   <= we_e_d;
            aw_e_q   <= aw_e_d;
            tn_e_q   <= tn_e_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            kind_e_q <= kind_e_d;
            we_m_q   <= we_m_d;
            aw_m_q   <= aw_m_d;
            tn_m_q   <= tn_m_d;
            rt_m_q   <= rt_m_d;
            we_w_q   <= we_w_d;
            aw_w_q   <= aw_w_d;
            tn_w_q   <= tn_w_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
